// File: rtl/mips_pkg.sv
// mips_pkg: shared fetch widths, reset PC and prefetch queue entry type
package mips_pkg;
  localparam int ADDR_W = 8;
  localparam int INST_W = 16;
  localparam logic [ADDR_W-1:0] RESET_PC = '0;
  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;
endpackage

// File: rtl/mips_fetch_fifo.sv
// mips_fetch_fifo: DEPTH-entry synchronous prefetch FIFO with flush
// Ports: push_i/wdata_i write tail, pop_i drops head, flush_i empties,
// rdata_o is the head entry, count_o the occupancy; rst_n async active-low.
module mips_fetch_fifo
  import mips_pkg::*;
#(
  parameter int W     = $bits(fetch_entry_t),
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  input  logic [W-1:0]               wdata_i,
  output logic [W-1:0]               rdata_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] count_q;
  always_ff @(posedge clk)
    if (push_i && !flush_i) mem_q[wr_q] <= wdata_i;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= push_i ? wr_q + AW'(1) : wr_q;
      rd_q    <= pop_i ? rd_q + AW'(1) : rd_q;
      count_q <= count_q + CW'(push_i) - CW'(pop_i);
    end
  assign rdata_o = mem_q[rd_q];
  assign count_o = count_q;
endmodule

// File: rtl/mips_fetch.sv
// mips_fetch: instruction fetch stage with PC, memory request issue and prefetch queue
// Ports: O_inst_addr/O_inst_req read the instruction memory, I_inst returns one
// cycle later; I_redirect/I_redirect_pc retarget fetch and flush; O_valid/I_ready
// hand O_inst/O_pc to decode; rst async active-low.
module mips_fetch #(
  parameter int                ADDR_W   = mips_pkg::ADDR_W,
  parameter int                INST_W   = mips_pkg::INST_W,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(mips_pkg::RESET_PC)
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] O_inst_addr,
  output logic              O_inst_req,
  input  logic [INST_W-1:0] I_inst,
  input  logic              I_redirect,
  input  logic [ADDR_W-1:0] I_redirect_pc,
  output logic              O_valid,
  input  logic              I_ready,
  output logic [INST_W-1:0] O_inst,
  output logic [ADDR_W-1:0] O_pc
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int EW = ADDR_W + INST_W;
  logic [ADDR_W-1:0] pc_q, pc_d, addr_q;
  logic inflight_q, inflight_d, push, pop;
  logic [CW-1:0] count;
  logic [CW:0] occ;
  logic [EW-1:0] head, hold_q, hold_d;
  // Occupancy counts the in-flight return so a full queue never overflows.
  // Gating with rst forces the strobes low the instant reset asserts.
  always_comb begin
    occ        = {1'b0, count} + (CW+1)'(inflight_q);
    O_inst_req = rst && !I_redirect && occ < (CW+1)'(DEPTH);
    O_valid    = rst && !I_redirect && count != '0;
    pop        = O_valid && I_ready;
    push       = inflight_q && !I_redirect;
    inflight_d = O_inst_req;
    pc_d       = I_redirect ? I_redirect_pc : O_inst_req ? pc_q + ADDR_W'(1) : pc_q;
    hold_d     = count != '0 ? head : hold_q;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      pc_q       <= RESET_PC;
      addr_q     <= RESET_PC;
      inflight_q <= 1'b0;
      hold_q     <= '0;
    end else begin
      pc_q       <= pc_d;
      addr_q     <= pc_q;
      inflight_q <= inflight_d;
      hold_q     <= hold_d;
    end
  mips_fetch_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
    .clk    (clk),
    .rst_n  (rst),
    .push_i (push),
    .pop_i  (pop),
    .flush_i(I_redirect),
    .wdata_i({addr_q, I_inst}),
    .rdata_o(head),
    .count_o(count)
  );
  assign O_inst_addr    = pc_q;
  // An empty queue keeps showing the last head rather than stale FIFO storage.
  assign {O_pc, O_inst} = count != '0 ? head : hold_d;
endmodule

// File: tb/tb_mips_fetch.sv
// tb_mips_fetch: scoreboard bench for mips_fetch against a {A5,addr} instruction memory
module tb_mips_fetch;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [7:0] O_inst_addr, I_redirect_pc = 8'h00, O_pc;
  logic O_inst_req, I_redirect = 1'b0, O_valid, I_ready = 1'b0;
  logic [15:0] I_inst = 16'h0000, O_inst;
  int checks = 0, failures = 0, nreq = 0, ndeliv = 0, n0;
  logic [7:0] sb[$];
  logic [7:0] exp_pc = 8'h00;
  logic s_req, s_valid;
  logic [7:0] s_pc, s_addr;

  mips_fetch #(.ADDR_W(8), .INST_W(16), .DEPTH(4), .RESET_PC(8'h00)) dut (
    .clk(clk), .rst(rst), .O_inst_addr(O_inst_addr), .O_inst_req(O_inst_req),
    .I_inst(I_inst), .I_redirect(I_redirect), .I_redirect_pc(I_redirect_pc),
    .O_valid(O_valid), .I_ready(I_ready), .O_inst(O_inst), .O_pc(O_pc)
  );

  always #5 clk = ~clk;
  always @(posedge clk) I_inst <= {8'hA5, O_inst_addr};

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Called at a falling edge: drive, settle, score this cycle, advance one cycle.
  task automatic cyc(input logic rdy, input logic redir = 1'b0, input logic [7:0] tgt = 8'h00);
    logic [7:0] e;
    I_ready = rdy;
    I_redirect = redir;
    I_redirect_pc = tgt;
    #1;
    s_req = O_inst_req;
    s_valid = O_valid;
    s_pc = O_pc;
    s_addr = O_inst_addr;
    if (redir) begin
      check("redir_req", O_inst_req, 0);
      check("redir_valid", O_valid, 0);
      sb.delete();
      exp_pc = tgt;
    end else begin
      if (O_valid && rdy) begin
        check("sb_nonempty", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("pc", O_pc, e);
          check("inst", O_inst, {8'hA5, e});
          ndeliv++;
        end
      end
      if (O_inst_req) begin
        check("addr", O_inst_addr, exp_pc);
        sb.push_back(exp_pc);
        exp_pc = exp_pc + 8'd1;
        nreq++;
      end
      check("occupancy", sb.size() <= 4, 1);
    end
    @(negedge clk);
    I_redirect = 1'b0;
  endtask

  task automatic do_reset();
    #2 rst = 1'b0;
    #1;
    check("rst_req", O_inst_req, 0);
    check("rst_valid", O_valid, 0);
    check("rst_addr", O_inst_addr, 0);
    check("rst_pc", O_pc, 0);
    check("rst_inst", O_inst, 0);
    sb.delete();
    exp_pc = 8'h00;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    #1;
    check("init_req", O_inst_req, 0);
    check("init_valid", O_valid, 0);
    check("init_addr", O_inst_addr, 0);
    check("init_inst", O_inst, 0);
    check("init_pc", O_pc, 0);
    @(negedge clk);
    rst = 1'b1;
    // streaming with decode always ready
    cyc(1);
    check("first_req", s_req, 1);
    check("first_addr", s_addr, 0);
    check("lat_c0", s_valid, 0);
    cyc(1);
    check("lat_c1", s_valid, 0);
    cyc(1);
    check("lat_c2", s_valid, 1);
    check("lat_pc", s_pc, 0);
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      check("stream_valid", s_valid, 1);
    end
    // back-pressure from cycle 0
    do_reset();
    n0 = nreq;
    for (int i = 0; i < 8; i++) cyc(0);
    check("bp_reqs", nreq - n0, 4);
    check("bp_stop", s_req, 0);
    check("bp_head_valid", s_valid, 1);
    check("bp_head_pc", s_pc, 0);
    n0 = ndeliv;
    cyc(1);
    check("bp_no_comb_req", s_req, 0);
    cyc(1);
    check("bp_resume", s_req, 1);
    check("bp_resume_addr", s_addr, 4);
    for (int i = 0; i < 6; i++) cyc(1);
    check("bp_deliv", ndeliv - n0 >= 5, 1);
    // redirect with 3 queued and 1 in flight
    do_reset();
    n0 = nreq;
    for (int i = 0; i < 4; i++) cyc(0);
    check("rd_setup", nreq - n0, 4);
    cyc(0, 1'b1, 8'h40);
    cyc(1);
    check("rd_t1_req", s_req, 1);
    check("rd_t1_addr", s_addr, 8'h40);
    check("rd_t1_valid", s_valid, 0);
    cyc(1);
    check("rd_t2_valid", s_valid, 0);
    cyc(1);
    check("rd_t3_valid", s_valid, 1);
    check("rd_t3_pc", s_pc, 8'h40);
    // wrap through 0xFF
    cyc(1, 1'b1, 8'hFE);
    n0 = ndeliv;
    for (int i = 0; i < 8; i++) cyc(1);
    check("wrap_deliv", ndeliv - n0 >= 4, 1);
    // async reset with a full queue
    for (int i = 0; i < 6; i++) cyc(0);
    check("full_stop", s_req, 0);
    do_reset();
    cyc(1);
    cyc(1);
    cyc(1);
    check("post_rst_valid", s_valid, 1);
    check("post_rst_pc", s_pc, 0);
    // random back-pressure
    n0 = ndeliv;
    for (int i = 0; i < 400; i++) cyc(1'($urandom_range(0, 1)));
    check("rand_progress", ndeliv - n0 > 100, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
